int_vec_ctrl: RTL and testbench
===============================

Name: int_vec_ctrl

Overview:
Parametrised interrupt/PC-sequencing controller for the single-cycle CPU.
- Owns the architectural PC register and selects each cycle between sequential `pc_next`, a vectored interrupt entry, or an `eret` return.
- Supports N prioritised, individually enabled, edge-triggered sources with an EPC/source stack, so higher-priority sources may nest.
- Sits between the next-PC logic and instruction fetch.

Parameters:
- WIDTH, 32, PC/EPC width in bits.
- N_SRC, 4, number of interrupt sources (1..16); index 0 is the highest priority.
- NEST_DEPTH, 2, EPC stack depth, i.e. the maximum number of nested handlers (1..8).
- RESET_PC, 0, PC value loaded on reset.
- VEC_BASE, 32'h00000004, handler address of source 0.
- VEC_STRIDE, 4, byte spacing between consecutive source vectors.
- EN_RESET, all ones, reset value of the enable register.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- int_req  in  N_SRC  raw interrupt request lines; a rising edge requests service.
- en_we  in  1  write strobe for the enable register.
- en_wdata  in  N_SRC  new enable value.
- eret  in  1  return-from-handler strobe, decoded from the current instruction.
- pc_next  in  WIDTH  sequential/branch next PC from the datapath.
- pc  out  WIDTH  architectural PC register.
- epc_top  out  WIDTH  EPC at the top of the stack; 0 when the stack is empty.
- cur_src  out  4  source id of the active handler; 4'hF when none is active.
- depth  out  4  number of occupied stack entries.
- pending  out  N_SRC  latched pending requests.
- int_taken  out  1  one-cycle pulse in the cycle after an interrupt entry.

Behaviour:
- Reset (asynchronous, any state including mid-handler):
  - pc=RESET_PC, pending=0, enable=EN_RESET, depth=0, stack cleared, cur_src=4'hF, epc_top=0, int_taken=0.
  - req_q (the registered copy of int_req) is cleared to 0, so a line already high when reset releases counts as a rising edge.
- Edge detect:
  - req_q <= int_req every cycle.
  - pending[i] is set when int_req[i] & ~req_q[i].
  - A level held high does not re-trigger.
- Enable register:
  - On en_we, enable <= en_wdata at the clock edge.
  - The new value first affects arbitration in the following cycle.
  - Disabled sources still latch pending; they are serviced once re-enabled.
- Arbitration (combinational, registered-cycle result):
  - eligible = pending & enable.
  - win = lowest set index of eligible.
  - Preempt when eligible≠0, depth<NEST_DEPTH, and (depth==0 or win<cur_src).
  - Equal or lower priority than the active handler waits.
- Per-cycle priority, exactly one action per cycle:
  1. eret with depth>0:
     - pc <= epc_top; pop the stack; depth-1.
     - cur_src <= the source of the new top, or 4'hF when the stack empties.
     - No interrupt is taken this cycle; pending is unchanged.
  2. Else, preempt:
     - push {pc_next, win}; depth+1; cur_src <= win.
     - pc <= VEC_BASE + win*VEC_STRIDE, truncated to WIDTH.
     - pending[win] cleared, unless a new rising edge on that source occurs in the same cycle, in which case it stays set.
     - int_taken=1 for one cycle.
  3. Else:
     - pc <= pc_next.
     - eret with depth==0 is ignored and treated as a normal step.
- Stack full (depth==NEST_DEPTH):
  - No entry is taken; requests remain pending.
  - There is no overflow, error, or wrap.
- After eret, an eligible pending source may be taken the next cycle. The pushed EPC is then the pc_next of the restored flow.
- Latency: pending is set one clock after the edge. Entry occurs on the next clock if the source is eligible and wins arbitration.

Test Plan:
- Reset, no requests, pc_next=pc+4 → pc steps 0,4,8; depth=0, cur_src=F; assert reset mid-handler → all outputs return to reset values immediately.
- Pulse int_req[2] while pc_next=0x100, defaults → next edge pending[2]=1, following edge pc=0x0C, epc_top=0x100, depth=1, int_taken=1; eret → pc=0x100, depth=0, cur_src=F.
- In handler for src 2, pulse src 3 → not taken (pending[3] stays 1); pulse src 0 with pc_next=0x20 → pc=0x04, depth=2, epc_top=0x20; eret → pc=0x20, cur_src=2; eret → src 3 taken the cycle after returning to the original flow.
- NEST_DEPTH=2 full (srcs 1 then 0 active), pulse another src → no entry, depth stays 2, pending held.
- en_we with en_wdata=4'b1011, pulse src 2 → pending[2]=1, never taken; write 4'b1111 → taken next cycle, pc=0x0C.
- eret and an eligible pending src in the same cycle → pop only; entry the next cycle with EPC=pc_next of the restored flow. eret with depth=0 → pc=pc_next.

Source files
------------

// File: rtl/int_vec_ctrl.sv
// Interrupt/PC sequencing controller: owns the PC, takes vectored, nestable
// interrupt entries from edge-triggered sources and returns on eret.
module int_vec_src (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic clr,
  output logic pend
);
  logic req_q;

  // A fresh edge wins over a same-cycle clear, so a re-request is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      req_q <= req;
      pend  <= (req & ~req_q) | (pend & ~clr);
    end
  end
endmodule

module int_vec_ctrl #(
  parameter int               WIDTH      = 32,
  parameter int               N_SRC      = 4,
  parameter int               NEST_DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter logic [WIDTH-1:0] VEC_BASE   = 'h4,
  parameter int               VEC_STRIDE = 4,
  parameter logic [N_SRC-1:0] EN_RESET   = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] int_req,
  input  logic             en_we,
  input  logic [N_SRC-1:0] en_wdata,
  input  logic             eret,
  input  logic [WIDTH-1:0] pc_next,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] epc_top,
  output logic [3:0]       cur_src,
  output logic [3:0]       depth,
  output logic [N_SRC-1:0] pending,
  output logic             int_taken
);
  logic [N_SRC-1:0] enable;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] clr;
  logic [3:0]       win;
  logic             do_ret;
  logic             take;
  logic [WIDTH-1:0] vec_pc;
  logic [WIDTH-1:0] epc_stk [NEST_DEPTH];
  logic [3:0]       src_stk [NEST_DEPTH];

  int_vec_src u_src [N_SRC-1:0] (
    .clk   (clk),
    .reset (reset),
    .req   (int_req),
    .clr   (clr),
    .pend  (pending)
  );

  assign eligible = pending & enable;

  // Lowest index wins: scan downward so the last hit is the smallest.
  always_comb begin
    win = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (eligible[i]) win = 4'(i);
  end

  always_comb begin
    epc_top = '0;
    cur_src = 4'hF;
    for (int i = 0; i < NEST_DEPTH; i++)
      if (int'(depth) == i + 1) begin
        epc_top = epc_stk[i];
        cur_src = src_stk[i];
      end
  end

  assign do_ret = eret && (depth != 4'd0);
  assign take   = !do_ret && (eligible != '0) && (int'(depth) < NEST_DEPTH) &&
                  ((depth == 4'd0) || (win < cur_src));
  assign vec_pc = VEC_BASE + WIDTH'(VEC_STRIDE) * WIDTH'(win);

  always_comb begin
    clr = '0;
    for (int i = 0; i < N_SRC; i++)
      clr[i] = take && (win == 4'(i));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_PC;
      enable    <= EN_RESET;
      depth     <= 4'd0;
      int_taken <= 1'b0;
      for (int i = 0; i < NEST_DEPTH; i++) begin
        epc_stk[i] <= '0;
        src_stk[i] <= 4'hF;
      end
    end else begin
      int_taken <= take;
      if (en_we) enable <= en_wdata;
      if (do_ret) begin
        pc    <= epc_top;
        depth <= depth - 4'd1;
      end else if (take) begin
        pc    <= vec_pc;
        depth <= depth + 4'd1;
        for (int i = 0; i < NEST_DEPTH; i++)
          if (int'(depth) == i) begin
            epc_stk[i] <= pc_next;
            src_stk[i] <= win;
          end
      end else begin
        pc <= pc_next;
      end
    end
  end
endmodule

// File: tb/tb_int_vec_ctrl.sv
// Randomized bench for int_vec_ctrl against a queue-based model of the
// interrupt rules, plus a few directed anchor checks.
module tb_int_vec_ctrl;
  localparam int NS = 4;
  localparam int ND = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NS-1:0] int_req;
  logic          en_we;
  logic [NS-1:0] en_wdata;
  logic          eret;
  logic [31:0]   pc_next;
  logic [31:0]   pc, epc_top;
  logic [3:0]    cur_src, depth;
  logic [NS-1:0] pending;
  logic          int_taken;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0]   m_pc;
  logic [NS-1:0] m_pend, m_en, m_reqq;
  logic          m_taken;
  logic [31:0]   m_epc[$];
  int            m_src[$];

  int_vec_ctrl #(.WIDTH(32), .N_SRC(NS), .NEST_DEPTH(ND)) dut (
    .clk(clk), .reset(reset), .int_req(int_req), .en_we(en_we),
    .en_wdata(en_wdata), .eret(eret), .pc_next(pc_next), .pc(pc),
    .epc_top(epc_top), .cur_src(cur_src), .depth(depth), .pending(pending),
    .int_taken(int_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_pend = '0; m_en = '1; m_reqq = '0; m_taken = 1'b0;
    m_epc.delete(); m_src.delete();
  endtask

  task automatic model_step();
    logic [NS-1:0] rise, elig;
    int w, cur;
    rise = int_req & ~m_reqq;
    elig = m_pend & m_en;
    w = -1;
    for (int i = NS - 1; i >= 0; i--) if (elig[i]) w = i;
    cur = (m_src.size() == 0) ? 15 : m_src[m_src.size()-1];
    m_taken = 1'b0;
    if (eret && m_src.size() > 0) begin
      m_pc = m_epc.pop_back();
      void'(m_src.pop_back());
      m_pend = m_pend | rise;
    end else if (w >= 0 && m_src.size() < ND && (m_src.size() == 0 || w < cur)) begin
      m_epc.push_back(pc_next);
      m_src.push_back(w);
      m_pc = 32'h4 + 32'(w) * 32'd4;
      m_pend[w] = 1'b0;
      m_pend = m_pend | rise;
      m_taken = 1'b1;
    end else begin
      m_pc = pc_next;
      m_pend = m_pend | rise;
    end
    m_reqq = int_req;
    if (en_we) m_en = en_wdata;
  endtask

  task automatic check_all();
    int d;
    d = m_src.size();
    chk("pc", pc, m_pc);
    chk("depth", 32'(depth), 32'(d));
    chk("cur_src", 32'(cur_src), (d == 0) ? 32'hF : 32'(m_src[d-1]));
    chk("epc_top", epc_top, (d == 0) ? 32'h0 : m_epc[d-1]);
    chk("pending", 32'(pending), 32'(m_pend));
    chk("int_taken", 32'(int_taken), 32'(m_taken));
  endtask

  task automatic cyc(input logic [NS-1:0] rq, input logic we, input logic [NS-1:0] wd,
                     input logic er, input logic [31:0] pn);
    int_req = rq; en_we = we; en_wdata = wd; eret = er; pc_next = pn;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_depth"}, 32'(depth), 32'h0);
    chk({tag, "_cur"}, 32'(cur_src), 32'hF);
    chk({tag, "_epc"}, epc_top, 32'h0);
    chk({tag, "_pend"}, 32'(pending), 32'h0);
    chk({tag, "_taken"}, 32'(int_taken), 32'h0);
  endtask

  initial begin
    logic [NS-1:0] rq;
    reset = 1'b1; int_req = '0; en_we = 1'b0; en_wdata = '0; eret = 1'b0; pc_next = '0;
    model_reset();
    #12;
    check_reset_vals("rst");
    reset = 1'b0;

    // Sequential stepping
    for (int i = 0; i < 3; i++) cyc('0, 1'b0, '0, 1'b0, m_pc + 32'd4);
    chk("seq_pc", pc, 32'hC);

    // Single entry on src 2 and return
    cyc(4'b0100, 1'b0, '0, 1'b0, 32'h100);
    chk("pend2", 32'(pending), 32'h4);
    cyc(4'b0100, 1'b0, '0, 1'b0, 32'h100);
    chk("ent_pc", pc, 32'hC);
    chk("ent_epc", epc_top, 32'h100);
    chk("ent_taken", 32'(int_taken), 32'h1);
    cyc(4'b0000, 1'b0, '0, 1'b1, 32'h10);
    chk("ret_pc", pc, 32'h100);
    chk("ret_cur", 32'(cur_src), 32'hF);

    // Disabled source latches but is not serviced until re-enabled
    cyc(4'b0000, 1'b1, 4'b1011, 1'b0, 32'h200);
    cyc(4'b0100, 1'b0, '0, 1'b0, 32'h204);
    cyc(4'b0000, 1'b0, '0, 1'b0, 32'h208);
    chk("dis_pc", pc, 32'h208);
    cyc(4'b0000, 1'b1, 4'b1111, 1'b0, 32'h20C);
    cyc(4'b0000, 1'b0, '0, 1'b0, 32'h210);
    chk("reen_pc", pc, 32'hC);
    cyc(4'b0000, 1'b0, '0, 1'b1, 32'h0);

    // Randomized traffic with one mid-run asynchronous reset
    rq = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NS; b++) if ($urandom_range(3) == 0) rq[b] = ~rq[b];
      cyc(rq, ($urandom_range(15) == 0), NS'($urandom_range(15) | ($urandom_range(1) ? 4'hF : 4'h0)),
          ($urandom_range(5) == 0), {$urandom_range(32'hFFFF), 2'b00});
      if (c == 1500) begin
        reset = 1'b1;
        #2;
        check_reset_vals("mid_rst");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
